boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Boot sequencer for cpuCore instruction memory.
- Receives a framed byte stream: header word count, instruction words, XOR checksum.
- Writes each word through the cpuCore debug write port (dbg_wr_en/dbg_addr/dbg_instr) while holding the core in reset.
- Releases the core only after the checksum matches. Replaces manual, testbench-driven program loading.

Parameters:
XLEN, 32, data/address width of the debug port
IMEM_WORDS, 256, maximum number of words a frame may carry
ADDR_BASE, 0, byte address of the first written word

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
load_req  in  1  start a new load; sampled in IDLE, RUN and ERR only
in_valid  in  1  byte-stream valid
in_data  in  8  stream byte
in_ready  out  1  byte accepted on in_valid & in_ready at the clk rising edge
dbg_wr_en  out  1  one-cycle instruction-memory write strobe
dbg_addr  out  XLEN  write byte address
dbg_instr  out  XLEN  write data
core_rst  out  1  reset to cpuCore; high except in RUN
busy  out  1  high in HDR/DATA/WRITE/CHK
done  out  1  high in RUN
err  out  1  high in ERR
words_loaded  out  $clog2(IMEM_WORDS+1)  words written in the current frame

Behaviour:
- Reset values (async assert, sync release):
  - state=IDLE, core_rst=1, dbg_wr_en=0, dbg_addr=ADDR_BASE, dbg_instr=0.
  - in_ready=0, busy=0, done=0, err=0, words_loaded=0.
  - Internal byte index, N and checksum cleared.
- All multi-byte fields are little-endian: first byte is [7:0].
- IDLE:
  - core_rst=1.
  - load_req -> HDR.
- HDR:
  - in_ready=1; collect 4 bytes into N.
  - On the 4th byte: N==0 or N>IMEM_WORDS -> ERR.
  - Otherwise -> DATA, with dbg_addr=ADDR_BASE, checksum=0, words_loaded=0.
- DATA:
  - in_ready=1; collect 4 bytes.
  - On the 4th accepted byte, register the assembled word into dbg_instr -> WRITE.
- WRITE (exactly 1 cycle):
  - dbg_wr_en=1, in_ready=0; dbg_addr and dbg_instr stable for the whole cycle.
  - Same edge updates: checksum^=dbg_instr, words_loaded+=1, dbg_addr+=4 (modulo 2^XLEN).
  - Next state: CHK if the new words_loaded==N, else DATA.
- CHK:
  - in_ready=1; collect 4 bytes.
  - On the 4th byte: equals checksum -> RUN, else -> ERR.
- RUN:
  - core_rst=0 and done=1, starting the first cycle after the last checksum byte is accepted.
  - load_req -> HDR; core_rst=1 on the next cycle.
  - Memory is not cleared; new words overwrite.
- ERR:
  - core_rst=1, err=1, held until load_req.
  - load_req -> HDR, which clears err.
- load_req is ignored while busy. in_valid is ignored outside HDR/DATA/CHK.
- in_ready is a registered state decode. Gaps in in_valid stall byte collection without losing partial words.
- Throughput: minimum 5 cycles per word.
- rst mid-frame: immediate return to reset values. Already-written memory words remain; no partial write is issued.

Test Plan:
- Happy path, N=2. load_req, then stream 02 00 00 00, 93 00 00 02, 03 21 10 00, checksum 90 21 10 02 back-to-back.
  -> dbg_wr_en pulses at addr 0 (0x02000093) and addr 4 (0x00102103).
  -> Then core_rst=0, done=1, words_loaded=2, err=0.
- Bad checksum: same frame with final byte 03.
  -> Both writes occur; err=1; core_rst stays 1; done=0.
- Header bounds:
  -> N=0 gives ERR after the 4th header byte, with no dbg_wr_en.
  -> N=257 (01 01 00 00) gives ERR.
  -> N=256 is accepted.
- Backpressure/gaps: happy-path frame with in_valid toggling every other cycle.
  -> Identical writes and result.
  -> in_ready=0 in each WRITE cycle.
  -> Bytes offered during WRITE are taken the following cycle.
- Reset mid-load: assert rst after the first word is written.
  -> All outputs return to reset values immediately.
  -> A subsequent full load succeeds.
- Reload from RUN:
  -> load_req raises core_rst the next cycle and enters HDR.
  -> A one-word frame 0x00C08193 (checksum 0x00C08193) writes addr 0 and returns to RUN.

Source files
------------

// File: rtl/boot_loader.sv
// Boot sequencer: takes a framed little-endian byte stream (word count, words, XOR checksum),
// writes each word through the cpuCore debug port and releases the core only after a good checksum.
module boot_loader #(
   parameter int unsigned         XLEN       = 32,
   parameter int unsigned         IMEM_WORDS = 256,
   parameter logic [XLEN-1:0]     ADDR_BASE  = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               load_req,
   input  logic                               in_valid,
   input  logic [7:0]                         in_data,
   output logic                               in_ready,
   output logic                               dbg_wr_en,
   output logic [XLEN-1:0]                    dbg_addr,
   output logic [XLEN-1:0]                    dbg_instr,
   output logic                               core_rst,
   output logic                               busy,
   output logic                               done,
   output logic                               err,
   output logic [$clog2(IMEM_WORDS+1)-1:0]    words_loaded
);

   localparam int unsigned CW = $clog2(IMEM_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_RUN,
      S_ERR
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      byte_idx;
   logic [23:0]     part;
   logic [31:0]     word;
   logic [CW-1:0]   n_words;
   logic [CW-1:0]   wl_next;
   logic [XLEN-1:0] checksum;
   logic            accept;
   logic            last_byte;
   logic            hdr_bad;

   // The fourth byte is not stored; the word is formed combinationally on its arrival.
   assign word      = {in_data, part};
   assign accept    = in_valid & in_ready;
   assign last_byte = accept && (byte_idx == 2'd3);
   assign hdr_bad   = (word == 32'd0) || (word > 32'(IMEM_WORDS));
   assign wl_next   = words_loaded + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      dbg_wr_en = 1'b0;
      core_rst  = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_req) state_nx = S_HDR;
         end
         S_HDR: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_byte) state_nx = hdr_bad ? S_ERR : S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_byte) state_nx = S_WRITE;
         end
         S_WRITE: begin
            dbg_wr_en = 1'b1;
            busy      = 1'b1;
            state_nx  = (wl_next == n_words) ? S_CHK : S_DATA;
         end
         S_CHK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_byte) state_nx = (XLEN'(word) == checksum) ? S_RUN : S_ERR;
         end
         S_RUN: begin
            core_rst = 1'b0;
            done     = 1'b1;
            if (load_req) state_nx = S_HDR;
         end
         S_ERR: begin
            err = 1'b1;
            if (load_req) state_nx = S_HDR;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx     <= '0;
         part         <= '0;
         n_words      <= '0;
         checksum     <= '0;
         dbg_addr     <= ADDR_BASE;
         dbg_instr    <= '0;
         words_loaded <= '0;
      end else begin
         if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            part     <= {in_data, part[23:8]};
         end
         case (state)
            S_HDR: begin
               if (last_byte && !hdr_bad) begin
                  n_words      <= CW'(word);
                  dbg_addr     <= ADDR_BASE;
                  checksum     <= '0;
                  words_loaded <= '0;
               end
            end
            S_DATA: begin
               if (last_byte) dbg_instr <= XLEN'(word);
            end
            S_WRITE: begin
               checksum     <= checksum ^ dbg_instr;
               words_loaded <= wl_next;
               dbg_addr     <= dbg_addr + XLEN'(4);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus queues the expected debug-port writes,
// an independent monitor pops and compares them on every write strobe.
module tb_boot_loader;

   localparam int XLEN = 32;
   localparam int IMEM = 256;
   localparam int CW   = $clog2(IMEM + 1);

   logic            clk;
   logic            rst;
   logic            load_req;
   logic            in_valid;
   logic [7:0]      in_data;
   logic            in_ready;
   logic            dbg_wr_en;
   logic [XLEN-1:0] dbg_addr;
   logic [XLEN-1:0] dbg_instr;
   logic            core_rst;
   logic            busy;
   logic            done;
   logic            err;
   logic [CW-1:0]   words_loaded;

   boot_loader #(
      .XLEN       (XLEN),
      .IMEM_WORDS (IMEM),
      .ADDR_BASE  ('0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_req     (load_req),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .dbg_wr_en    (dbg_wr_en),
      .dbg_addr     (dbg_addr),
      .dbg_instr    (dbg_instr),
      .core_rst     (core_rst),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] wbuf[IMEM];
   logic [31:0] mon_a;
   logic [31:0] mon_d;

   task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst === 1'b0 && dbg_wr_en === 1'b1) begin
         if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h:%h required=none", dbg_addr, dbg_instr);
         end else begin
            mon_a = exp_addr.pop_front();
            mon_d = exp_data.pop_front();
            check_w("wr_addr", dbg_addr, mon_a);
            check_w("wr_data", dbg_instr, mon_d);
         end
         check_b("ready_in_write", in_ready, 1'b0);
      end
   end

   task automatic check_reset_vals();
      check_b("rst_in_ready", in_ready, 1'b0);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
      check_b("rst_err", err, 1'b0);
      check_b("rst_core_rst", core_rst, 1'b1);
      check_b("rst_wr_en", dbg_wr_en, 1'b0);
      check_w("rst_addr", dbg_addr, 32'd0);
      check_w("rst_instr", dbg_instr, 32'd0);
      check_w("rst_words", 32'(words_loaded), 32'd0);
   endtask

   // Offers one byte until accepted; then optionally idles in_valid (gap 1: one cycle, 2: random 0-2).
   task automatic send_byte(input logic [7:0] b, input int gap, output int edges);
      logic rdy;
      int   n;
      load_req = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      edges    = 0;
      do begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         edges++;
      end while (!rdy && edges < 20);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout actual=not_accepted required=accepted");
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (n) begin
         load_req = 1'($urandom);
         @(posedge clk);
         #1;
      end
      load_req = 1'b0;
   endtask

   task automatic start_load();
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      check_b("start_busy", busy, 1'b1);
      check_b("start_core_rst", core_rst, 1'b1);
      check_b("start_err", err, 1'b0);
   endtask

   task automatic run_frame(input logic [31:0] hdr, input bit corrupt, input int gaps);
      logic [7:0]  bq[$];
      logic [31:0] ck;
      bit          hdr_ok;
      bit          ok;
      int          nw;
      int          total;
      int          e;
      hdr_ok = (hdr != 0) && (hdr <= IMEM);
      nw     = hdr_ok ? int'(hdr) : 0;
      ck     = '0;
      total  = 0;
      for (int i = 0; i < 4; i++) bq.push_back(hdr[8*i +: 8]);
      for (int w = 0; w < nw; w++) begin
         for (int i = 0; i < 4; i++) bq.push_back(wbuf[w][8*i +: 8]);
         exp_addr.push_back(32'(w * 4));
         exp_data.push_back(wbuf[w]);
         ck ^= wbuf[w];
      end
      if (hdr_ok) begin
         if (corrupt) ck ^= 32'h0100_0000;
         for (int i = 0; i < 4; i++) bq.push_back(ck[8*i +: 8]);
      end
      for (int i = 0; i < bq.size(); i++) begin
         send_byte(bq[i], (i == bq.size() - 1) ? 0 : gaps, e);
         total += e;
      end
      check_w("writes_pending", 32'(exp_addr.size()), 32'd0);
      check_b("end_busy", busy, 1'b0);
      if (!hdr_ok) begin
         check_b("hdr_err", err, 1'b1);
         check_b("hdr_done", done, 1'b0);
         check_b("hdr_core_rst", core_rst, 1'b1);
      end else begin
         ok = !corrupt;
         check_b("end_done", done, ok);
         check_b("end_err", err, !ok);
         check_b("end_core_rst", core_rst, !ok);
         check_w("end_words", 32'(words_loaded), 32'(nw));
      end
      if (gaps == 0) check_w("frame_cycles", 32'(total), 32'(bq.size() + nw));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      rst      = 1'b1;
      load_req = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      check_reset_vals();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      // in_valid outside a frame must be ignored
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_reset_vals();

      wbuf[0] = 32'h0200_0093;
      wbuf[1] = 32'h0010_2103;
      start_load();
      run_frame(32'd2, 1'b0, 0);
      start_load();
      run_frame(32'd2, 1'b1, 0);
      start_load();
      run_frame(32'd0, 1'b0, 0);
      start_load();
      run_frame(32'd257, 1'b0, 0);
      start_load();
      run_frame(32'd2, 1'b0, 1);

      // Reset after the first of three words has been written.
      start_load();
      send_byte(8'h03, 0, e);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 0, e);
      exp_addr.push_back(32'd0);
      exp_data.push_back(wbuf[0]);
      for (int i = 0; i < 4; i++) send_byte(wbuf[0][8*i +: 8], 0, e);
      @(posedge clk);
      #1;
      check_w("midrst_written", 32'(exp_addr.size()), 32'd0);
      rst = 1'b1;
      #1;
      check_reset_vals();
      @(posedge clk);
      #1;
      rst = 1'b0;
      start_load();
      run_frame(32'd2, 1'b0, 0);

      wbuf[0] = 32'h00C0_8193;
      start_load();
      run_frame(32'd1, 1'b0, 0);

      for (int w = 0; w < IMEM; w++) wbuf[w] = $urandom;
      start_load();
      run_frame(32'd256, 1'b0, 2);

      for (int f = 0; f < 12; f++) begin
         for (int w = 0; w < 16; w++) wbuf[w] = $urandom;
         start_load();
         run_frame(32'($urandom_range(1, 12)), ($urandom_range(0, 2) == 0), int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
